mux_arbitro: RTL and testbench

MUX_ARBITRO -- requirements
Module: mux_arbitro

---
 rtl/paquete_mux.sv | 7 +
 rtl/arbitro_rr.sv | 36 +++
 rtl/mux_arbitro.sv | 91 +++++++++
 tb/tb_mux_arbitro.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/paquete_mux.sv
// Shared definitions for the mux/demux/FIFO family: arbitration mode encodings.
package paquete_mux;

  localparam logic MODO_PRIORIDAD_FIJA = 1'b0;
  localparam logic MODO_ROUND_ROBIN    = 1'b1;

endpackage

// File: rtl/arbitro_rr.sv
// Combinational grant logic: fixed priority from channel 0, or round-robin
// searching upward from the channel after the last one granted.
module arbitro_rr
  import paquete_mux::*;
#(
  parameter int unsigned NUM_CANALES = 4,
  localparam int unsigned SEL_BITS   = $clog2(NUM_CANALES)
) (
  input  logic [NUM_CANALES-1:0] validos_i,
  input  logic [SEL_BITS-1:0]    ultimo_i,
  input  logic                   modo_i,
  output logic [NUM_CANALES-1:0] grant_o,
  output logic [SEL_BITS-1:0]    indice_o,
  output logic                   grant_valido_o
);

  logic [SEL_BITS-1:0] base;
  logic [SEL_BITS-1:0] cand;

  always_comb begin
    indice_o       = '0;
    grant_valido_o = 1'b0;
    cand           = '0;
    base           = (modo_i == MODO_ROUND_ROBIN) ? ultimo_i + SEL_BITS'(1) : '0;
    // NUM_CANALES is a power of two, so the index addition wraps naturally.
    for (int i = 0; i < NUM_CANALES; i++) begin
      cand = base + SEL_BITS'(i);
      if (!grant_valido_o && validos_i[cand]) begin
        grant_valido_o = 1'b1;
        indice_o       = cand;
      end
    end
    grant_o = NUM_CANALES'(grant_valido_o) << indice_o;
  end

endmodule

// File: rtl/mux_arbitro.sv
// Arbitrated N:1 mux: pops one upstream channel per cycle and registers its word,
// index and a valid strobe; gated by enable and downstream backpressure.
module mux_arbitro
  import paquete_mux::*;
#(
  parameter int unsigned DATA_BITS   = 4,
  parameter int unsigned NUM_CANALES = 4,
  localparam int unsigned SEL_BITS   = $clog2(NUM_CANALES)
) (
  input  logic                             clk,
  input  logic                             reset_L,
  input  logic                             enb,
  input  logic                             modo,
  input  logic [NUM_CANALES*DATA_BITS-1:0] entradas,
  input  logic [NUM_CANALES-1:0]           validos,
  input  logic                             pausa,
  output logic [NUM_CANALES-1:0]           pop,
  output logic [DATA_BITS-1:0]             salida,
  output logic                             valido_salida,
  output logic [SEL_BITS-1:0]              selector
);

  logic [NUM_CANALES-1:0] grant;
  logic [SEL_BITS-1:0]    indice;
  logic                   grant_valido;
  logic                   hay_grant;

  logic [DATA_BITS-1:0] salida_q, salida_d;
  logic [SEL_BITS-1:0]  selector_q, selector_d;
  logic [SEL_BITS-1:0]  ultimo_q, ultimo_d;
  logic                 valido_q, valido_d;
  logic [DATA_BITS-1:0] dato;

  arbitro_rr #(
    .NUM_CANALES (NUM_CANALES)
  ) u_arbitro (
    .validos_i      (validos),
    .ultimo_i       (ultimo_q),
    .modo_i         (modo),
    .grant_o        (grant),
    .indice_o       (indice),
    .grant_valido_o (grant_valido)
  );

  // reset_L gates pop combinationally so no read strobe escapes during reset.
  assign hay_grant = reset_L & enb & ~pausa & grant_valido;
  assign pop       = hay_grant ? grant : '0;

  always_comb begin
    dato = '0;
    for (int i = 0; i < NUM_CANALES; i++) begin
      dato = dato | (entradas[i*DATA_BITS +: DATA_BITS] & {DATA_BITS{grant[i]}});
    end
  end

  always_comb begin
    salida_d   = salida_q;
    selector_d = selector_q;
    ultimo_d   = ultimo_q;
    valido_d   = 1'b0;
    if (!enb) begin
      salida_d   = '0;
      selector_d = '0;
    end else if (hay_grant) begin
      salida_d   = dato;
      selector_d = indice;
      ultimo_d   = indice;
      valido_d   = 1'b1;
    end
  end

  // ultimo resets to the last channel so the first round-robin search starts at 0.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      salida_q   <= '0;
      selector_q <= '0;
      ultimo_q   <= SEL_BITS'(NUM_CANALES - 1);
      valido_q   <= 1'b0;
    end else begin
      salida_q   <= salida_d;
      selector_q <= selector_d;
      ultimo_q   <= ultimo_d;
      valido_q   <= valido_d;
    end
  end

  assign salida        = salida_q;
  assign selector      = selector_q;
  assign valido_salida = valido_q;

endmodule

// File: tb/tb_mux_arbitro.sv
// Bench for mux_arbitro: vector table with expected pop per row, outputs checked
// one edge later through a scoreboard queue, plus an async mid-stream reset.
module tb_mux_arbitro;

  localparam int unsigned DB = 4;
  localparam int unsigned NC = 4;
  localparam int unsigned SB = 2;

  logic           clk = 1'b0;
  logic           reset_L;
  logic           enb;
  logic           modo;
  logic           pausa;
  logic [NC*DB-1:0] entradas;
  logic [NC-1:0]  validos;
  logic [NC-1:0]  pop;
  logic [DB-1:0]  salida;
  logic           valido_salida;
  logic [SB-1:0]  selector;

  always #5 clk = ~clk;

  mux_arbitro #(
    .DATA_BITS   (DB),
    .NUM_CANALES (NC)
  ) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .enb           (enb),
    .modo          (modo),
    .entradas      (entradas),
    .validos       (validos),
    .pausa         (pausa),
    .pop           (pop),
    .salida        (salida),
    .valido_salida (valido_salida),
    .selector      (selector)
  );

  typedef struct {
    logic        enb;
    logic        modo;
    logic        pausa;
    logic [3:0]  validos;
    logic [15:0] entradas;
    logic [3:0]  exp_pop;
  } vec_t;

  typedef struct {
    logic [3:0] salida;
    logic [1:0] sel;
    logic       valido;
  } sal_t;

  vec_t tabla[$];
  sal_t cola[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [3:0] hold_sal;
  logic [1:0] hold_sel;

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nombre, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic m, input logic p,
                              input logic [3:0] v, input logic [15:0] d, input logic [3:0] ep);
    vec_t r;
    r.enb = e; r.modo = m; r.pausa = p; r.validos = v; r.entradas = d; r.exp_pop = ep;
    return r;
  endfunction

  // Drive one row, check pop in-cycle, queue the expected registered result.
  task automatic apply(input vec_t v);
    sal_t e;
    enb = v.enb; modo = v.modo; pausa = v.pausa; validos = v.validos; entradas = v.entradas;
    #2;
    chk("pop", 32'(pop), 32'(v.exp_pop));
    if (!v.enb) begin
      hold_sal = '0;
      hold_sel = '0;
      e.valido = 1'b0;
    end else if (v.exp_pop != 4'b0000) begin
      for (int i = 0; i < 4; i++) begin
        if (v.exp_pop[i]) begin
          hold_sel = 2'(i);
          hold_sal = v.entradas[i*4 +: 4];
        end
      end
      e.valido = 1'b1;
    end else begin
      e.valido = 1'b0;
    end
    e.salida = hold_sal;
    e.sel    = hold_sel;
    cola.push_back(e);
    @(posedge clk);
    #1;
    if (cola.size() == 0) begin
      chk("cola_vacia", 32'(1), 32'(0));
    end else begin
      e = cola.pop_front();
      chk("salida", 32'(salida), 32'(e.salida));
      chk("selector", 32'(selector), 32'(e.sel));
      chk("valido_salida", 32'(valido_salida), 32'(e.valido));
    end
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    #1;
    chk("rst_pop", 32'(pop), 32'(0));
    chk("rst_salida", 32'(salida), 32'(0));
    chk("rst_valido", 32'(valido_salida), 32'(0));
    reset_L  = 1'b1;
    hold_sal = '0;
    hold_sel = '0;
  endtask

  localparam logic [15:0] D = 16'h4321;

  initial begin
    // Case 1: fixed priority, ch1=5, ch3=A
    for (int i = 0; i < 3; i++) tabla.push_back(mk(1, 0, 0, 4'b1010, 16'hA050, 4'b0010));
    // Case 2: round-robin after reset
    tabla.push_back(mk(1, 1, 0, 4'b1111, D, 4'b0001));
    tabla.push_back(mk(1, 1, 0, 4'b1111, D, 4'b0010));
    tabla.push_back(mk(1, 1, 0, 4'b1111, D, 4'b0100));
    tabla.push_back(mk(1, 1, 0, 4'b1111, D, 4'b1000));
    tabla.push_back(mk(1, 1, 0, 4'b1111, D, 4'b0001));
    // Case 3: pausa mid-stream, resume at next channel
    tabla.push_back(mk(1, 1, 0, 4'b1111, D, 4'b0010));
    tabla.push_back(mk(1, 1, 1, 4'b1111, D, 4'b0000));
    tabla.push_back(mk(1, 1, 1, 4'b1111, D, 4'b0000));
    tabla.push_back(mk(1, 1, 0, 4'b1111, D, 4'b0100));
    // Case 4: enable off clears outputs, ultimo kept
    tabla.push_back(mk(0, 1, 0, 4'b1111, D, 4'b0000));
    tabla.push_back(mk(1, 1, 0, 4'b1111, D, 4'b1000));
    // Mode switches take effect in the same cycle
    tabla.push_back(mk(1, 0, 0, 4'b1100, D, 4'b0100));
    tabla.push_back(mk(1, 1, 0, 4'b1100, D, 4'b1000));
    tabla.push_back(mk(1, 1, 0, 4'b0110, D, 4'b0010));
    tabla.push_back(mk(1, 1, 0, 4'b0000, D, 4'b0000));
    tabla.push_back(mk(1, 0, 0, 4'b1000, D, 4'b1000));
    // Case 6: single channel, round-robin
    for (int i = 0; i < 4; i++) tabla.push_back(mk(1, 1, 0, 4'b0001, 16'hBA9E, 4'b0001));

    reset_L = 1'b0; enb = 1'b1; modo = 1'b1; pausa = 1'b0;
    validos = 4'b1111; entradas = D; hold_sal = '0; hold_sel = '0;
    #3;
    chk("rst_pop_t0", 32'(pop), 32'(0));
    @(posedge clk);
    #1;
    chk("rst_salida_t0", 32'(salida), 32'(0));
    chk("rst_selector_t0", 32'(selector), 32'(0));
    chk("rst_valido_t0", 32'(valido_salida), 32'(0));
    #2;
    reset_L = 1'b1;

    for (int i = 0; i < tabla.size(); i++) begin
      if (i == 3) do_reset();
      apply(tabla[i]);
    end

    // Case 5: async reset between edges while a word is on the output
    apply(mk(1, 1, 0, 4'b1111, D, 4'b0010));
    #2;
    reset_L = 1'b0;
    #1;
    chk("async_salida", 32'(salida), 32'(0));
    chk("async_selector", 32'(selector), 32'(0));
    chk("async_valido", 32'(valido_salida), 32'(0));
    chk("async_pop", 32'(pop), 32'(0));
    #1;
    reset_L  = 1'b1;
    hold_sal = '0;
    hold_sel = '0;
    apply(mk(1, 1, 0, 4'b1100, D, 4'b0100));
    apply(mk(1, 1, 0, 4'b1100, D, 4'b1000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
